// File: rtl/urv_iram_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : urv_iram_port_arbiter_pkg
// Brief  : State/owner encodings and address range helper for the IRAM
//          port-B arbiter.
// Rev    : 1.0  initial release
// ============================================================================
package urv_iram_port_arbiter_pkg;

    localparam int c_BURST_W = 4;

    typedef enum logic [1:0] {
        ST_SHARED    = 2'd0,
        ST_LOCK_WAIT = 2'd1,
        ST_LOCKED    = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_HOST = 2'd2
    } owner_t;

    // The limit carries one extra bit so a 4 GiB size cannot wrap to zero.
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [32:0] limit);
        return ({1'b0, addr} < limit);
    endfunction

endpackage
`default_nettype wire

// File: rtl/urv_iram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : urv_iram_port_arbiter_if
// Brief  : Request/grant/read-return bundle of one IRAM port-B requester.
// Rev    : 1.0  initial release
// ============================================================================
interface urv_iram_port_arbiter_if;

    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  bwe;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, bwe, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, bwe, wdata,
        output gnt, rvalid, rdata
    );

endinterface
`default_nettype wire

// File: rtl/urv_iram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : urv_iram_port_arbiter
// Brief  : Shares IRAM port B between the CPU data port and a host loader,
//          with bounded host bursts and a host exclusive-lock mode.
// Rev    : 1.0  initial release
// ============================================================================
module urv_iram_port_arbiter
    import urv_iram_port_arbiter_pkg::*;
#(
    parameter int G_SIZE       = 65536,
    parameter int G_HOST_BURST = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    urv_iram_port_arbiter_if.slave         dm,
    urv_iram_port_arbiter_if.slave         host,
    input  logic                           host_lock,
    output logic                           host_locked,
    output logic                           err,
    output logic                           enb,
    output logic                           web,
    output logic [31:0]                    ab,
    output logic [3:0]                     bweb,
    output logic [31:0]                    db,
    input  logic [31:0]                    qb
);

    localparam logic [32:0]          c_LIMIT     = 33'(G_SIZE);
    localparam logic [c_BURST_W-1:0] c_BURST_MAX = c_BURST_W'(G_HOST_BURST);

    arb_state_t           r_state;
    owner_t               r_rd_owner;
    logic [c_BURST_W-1:0] r_burst;
    logic                 r_rd_oor;
    logic                 r_err;
    logic                 r_locked;

    logic        w_cpu_allowed;
    logic        w_cpu_turn;
    logic        w_host_gnt;
    logic        w_cpu_gnt;
    logic        w_any_gnt;
    logic        w_sel_we;
    logic [31:0] w_sel_addr;
    logic [3:0]  w_sel_bwe;
    logic [31:0] w_sel_wdata;
    logic        w_in_range;

    // A lock request in the same cycle already blocks the CPU.
    assign w_cpu_allowed = (r_state == ST_SHARED) && !host_lock;
    assign w_cpu_turn    = w_cpu_allowed && dm.req && (r_burst == c_BURST_MAX);
    assign w_host_gnt    = !rst && host.req && !w_cpu_turn;
    assign w_cpu_gnt     = !rst && dm.req && w_cpu_allowed && !w_host_gnt;
    assign w_any_gnt     = w_host_gnt || w_cpu_gnt;

    assign w_sel_we    = w_host_gnt ? host.we    : dm.we;
    assign w_sel_addr  = w_host_gnt ? host.addr  : dm.addr;
    assign w_sel_bwe   = w_host_gnt ? host.bwe   : dm.bwe;
    assign w_sel_wdata = w_host_gnt ? host.wdata : dm.wdata;
    assign w_in_range  = addr_in_range(w_sel_addr, c_LIMIT);

    assign dm.gnt   = w_cpu_gnt;
    assign host.gnt = w_host_gnt;

    assign enb  = w_any_gnt && w_in_range;
    assign web  = enb && w_sel_we;
    assign ab   = w_any_gnt ? w_sel_addr  : 32'd0;
    assign bweb = w_any_gnt ? w_sel_bwe   : 4'd0;
    assign db   = w_any_gnt ? w_sel_wdata : 32'd0;

    // Read data is steered by the owner latched at grant time; out-of-range reads return zero.
    assign dm.rvalid   = !rst && (r_rd_owner == OWN_CPU);
    assign host.rvalid = !rst && (r_rd_owner == OWN_HOST);
    assign dm.rdata    = (dm.rvalid && !r_rd_oor)   ? qb : 32'd0;
    assign host.rdata  = (host.rvalid && !r_rd_oor) ? qb : 32'd0;

    assign host_locked = r_locked && !rst;
    assign err         = r_err && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_SHARED;
            r_burst    <= '0;
            r_rd_owner <= OWN_NONE;
            r_rd_oor   <= 1'b0;
            r_err      <= 1'b0;
            r_locked   <= 1'b0;
        end else begin
            r_err    <= w_any_gnt && !w_in_range;
            r_rd_oor <= !w_in_range;
            if (w_any_gnt && !w_sel_we)
                r_rd_owner <= w_host_gnt ? OWN_HOST : OWN_CPU;
            else
                r_rd_owner <= OWN_NONE;

            case (r_state)
                ST_SHARED: begin
                    if (host_lock)
                        r_state <= ST_LOCK_WAIT;
                    if (w_cpu_gnt || !dm.req)
                        r_burst <= '0;
                    else if (w_host_gnt && (r_burst != c_BURST_MAX))
                        r_burst <= r_burst + 1'b1;
                end
                ST_LOCK_WAIT: begin
                    if (!host_lock) begin
                        r_state <= ST_SHARED;
                        r_burst <= '0;
                    end else if (r_rd_owner != OWN_CPU) begin
                        r_state  <= ST_LOCKED;
                        r_locked <= 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (!host_lock) begin
                        r_state  <= ST_SHARED;
                        r_burst  <= '0;
                        r_locked <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= ST_SHARED;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
